// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: shared FSM, instruction-class, ALU and mux-select encodings
package multi_cycle_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
  typedef enum logic [3:0] {C_RTYPE, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} iclass_t;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b1111;
  localparam logic [3:0] ALU_XOR = 4'b1110;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic SRCA_PC = 1'b0, SRCA_RS = 1'b1;
  localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMMSH = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2, WD_LUI = 2'd3;
  function automatic logic [3:0] rtype_alu_op(input logic [5:0] funct);
    return (funct == F_SUBU) ? ALU_SUB : (funct == F_SLL) ? ALU_SLL :
           (funct == F_XOR) ? ALU_XOR : ALU_ADD;
  endfunction
endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// mc_decode: maps opcode/funct to an instruction class and a legality flag
module mc_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class,
  output logic       o_legal
);
  logic w_r_ok;
  assign w_r_ok = i_funct inside {F_ADDU, F_SUBU, F_SLL, F_XOR};
  always_comb begin
    o_class = C_ILL;
    case (i_opcode)
      OP_RTYPE: o_class = (i_funct == F_JR) ? C_JR : w_r_ok ? C_RTYPE : C_ILL;
      OP_ORI:   o_class = C_ORI;
      OP_LUI:   o_class = C_LUI;
      OP_LW:    o_class = C_LW;
      OP_SW:    o_class = C_SW;
      OP_BEQ:   o_class = C_BEQ;
      OP_J:     o_class = C_J;
      OP_JAL:   o_class = C_JAL;
      default:  o_class = C_ILL;
    endcase
  end
  assign o_legal = o_class != C_ILL;
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-subset control FSM with memory-wait timeout and sticky faults
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_src,
  output logic       illegal,
  output logic       timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t     r_state, w_next;
  logic [CW-1:0] r_wait;
  logic       r_illegal, r_timeout;
  iclass_t    w_class;
  logic       w_legal, w_waiting, w_expire;
  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
  mc_decode u_decode (.i_opcode(opcode), .i_funct(funct), .o_class(w_class), .o_legal(w_legal));
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  // ready in the last allowed cycle still completes; only a low final cycle expires
  assign w_expire  = w_waiting && !mem_ready && (r_wait == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (w_waiting && !mem_ready) ? r_wait + CW'(1) : '0;
      r_illegal <= r_illegal | ((r_state == S_DECODE) && !w_legal);
      r_timeout <= r_timeout | w_expire;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_expire ? S_ERR : S_FETCH;
      S_DECODE: w_next = !w_legal ? S_ERR : (w_class inside {C_J, C_JAL, C_JR}) ? S_FETCH : S_EXEC;
      S_EXEC:   w_next = (w_class inside {C_LW, C_SW}) ? S_MEM :
                         (w_class inside {C_LUI, C_BEQ}) ? S_FETCH : S_WB;
      S_MEM:    w_next = mem_ready ? ((w_class == C_SW) ? S_FETCH : S_WB) : w_expire ? S_ERR : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_ERR;
    endcase
  end
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    pc_src      = PC_ALU;
    alu_op      = ALU_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RT;
    reg_dst     = DST_RT;
    wd_src      = WD_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        alu_src_b  = SRCB_4;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMMSH;
        w_pc_write  = w_class inside {C_J, C_JAL, C_JR};
        pc_src      = (w_class == C_JR) ? PC_RS : PC_JUMP;
        w_reg_write = w_class == C_JAL;
        reg_dst     = DST_RA;
        wd_src      = WD_PC;
      end
      S_EXEC: begin
        alu_src_a   = SRCA_RS;
        alu_src_b   = (w_class inside {C_RTYPE, C_BEQ}) ? SRCB_RT : SRCB_IMM;
        alu_op      = (w_class == C_RTYPE) ? rtype_alu_op(funct) : (w_class == C_ORI) ? ALU_OR :
                      (w_class == C_BEQ) ? ALU_SUB : ALU_ADD;
        w_pc_write  = (w_class == C_BEQ) && zero;
        pc_src      = PC_ALUOUT;
        w_reg_write = w_class == C_LUI;
        wd_src      = WD_LUI;
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = w_class == C_SW;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = (w_class == C_RTYPE) ? DST_RD : DST_RT;
        wd_src      = (w_class == C_LW) ? WD_MEM : WD_ALU;
      end
      default: ;
    endcase
  end
  // strobes are gated by reset so nothing fires while the FSM is held in FETCH
  assign mem_req   = rst_n & w_mem_req;
  assign mem_we    = rst_n & w_mem_we;
  assign ir_write  = rst_n & w_ir_write;
  assign pc_write  = rst_n & w_pc_write;
  assign reg_write = rst_n & w_reg_write;
  assign illegal   = r_illegal;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: randomized instruction stream checked against a per-instruction cycle-script model
module tb_multi_cycle_ctrl;
  localparam int TO = 16;
  localparam bit [3:0] ADD = 4'b0010, SUB = 4'b0110, ORR = 4'b0001, SLL = 4'b1111, XRR = 4'b1110;
  localparam bit [17:0] M_STB = 18'h3E000, M_PS = 18'h01800, M_ALU = 18'h007F0;
  localparam bit [17:0] M_OPB = 18'h007B0, M_RD = 18'h0000C, M_WD = 18'h00003;
  localparam bit [5:0] SW_OP = 6'b101011;
  typedef struct {bit [17:0] v; bit [17:0] m; bit r;} cyc_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic mem_req, mem_we, ir_write, pc_write, alu_src_a, reg_write, illegal, timeout;
  logic [1:0] pc_src, alu_src_b, reg_dst, wd_src;
  logic [3:0] alu_op;
  logic [17:0] obs;
  int checks = 0, errors = 0;
  cyc_t q[$];
  bit [5:0] ops[12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101,
                        6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  bit [5:0] fns[5] = '{6'b100001, 6'b100011, 6'b000000, 6'b100110, 6'b001000};
  always #5 clk = ~clk;
  multi_cycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .wd_src(wd_src), .illegal(illegal), .timeout(timeout)
  );
  assign obs = {mem_req, mem_we, ir_write, pc_write, reg_write, pc_src, alu_op, alu_src_a, alu_src_b, reg_dst, wd_src};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit [17:0] pk(input bit mr, mw, ir, pw, rw, input bit [1:0] ps, input bit [3:0] op,
                                   input bit a, input bit [1:0] b, rd, wd);
    return {mr, mw, ir, pw, rw, ps, op, a, b, rd, wd};
  endfunction
  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction
  function automatic bit [3:0] ralu(input bit [5:0] fn);
    return (fn == 6'b100011) ? SUB : (fn == 6'b000000) ? SLL : (fn == 6'b100110) ? XRR : ADD;
  endfunction
  task automatic push(input bit [17:0] v, input bit [17:0] m, input bit r);
    cyc_t c;
    c.v = v; c.m = m; c.r = r;
    q.push_back(c);
  endtask
  task automatic fetch(input int nf);
    for (int i = 0; i < nf; i++) push(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_STB, 1'b0);
    push(pk(1, 0, 1, 1, 0, 0, ADD, 0, 1, 0, 0), M_STB | M_PS | M_ALU, 1'b1);
  endtask
  // expected per-cycle output script for one instruction, derived from the instruction rules
  task automatic build(input bit [5:0] op, input bit [5:0] fn, input bit z, input int nf, input int nm);
    bit sw;
    bit [17:0] dec;
    dec = pk(0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0);
    sw = op == SW_OP;
    opcode = op; funct = fn; zero = z;
    q.delete();
    fetch(nf);
    if (op == 6'b000000 && fn == 6'b001000) push(pk(0, 0, 0, 1, 0, 3, ADD, 0, 3, 0, 0), M_STB | M_ALU | M_PS, rb());
    else if (op == 6'b000010) push(pk(0, 0, 0, 1, 0, 2, ADD, 0, 3, 0, 0), M_STB | M_ALU | M_PS, rb());
    else if (op == 6'b000011) push(pk(0, 0, 0, 1, 1, 2, ADD, 0, 3, 2, 2), M_STB | M_ALU | M_PS | M_RD | M_WD, rb());
    else begin
      push(dec, M_STB | M_ALU, rb());
      case (op)
        6'b000000: begin
          push(pk(0, 0, 0, 0, 0, 0, ralu(fn), 1, 0, 0, 0), M_STB | M_ALU, rb());
          push(pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), M_STB | M_RD | M_WD, rb());
        end
        6'b001101: begin
          push(pk(0, 0, 0, 0, 0, 0, ORR, 0, 2, 0, 0), M_STB | M_OPB, rb());
          push(pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), M_STB | M_RD | M_WD, rb());
        end
        6'b001111: push(pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3), M_STB | M_RD | M_WD, rb());
        6'b100011, 6'b101011: begin
          push(pk(0, 0, 0, 0, 0, 0, ADD, 1, 2, 0, 0), M_STB | M_ALU, rb());
          for (int i = 0; i < nm; i++) push(pk(1, sw, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_STB, 1'b0);
          push(pk(1, sw, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_STB, 1'b1);
          if (!sw) push(pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), M_STB | M_RD | M_WD, rb());
        end
        6'b000100: push(pk(0, 0, 0, z, 0, 1, SUB, 1, 0, 0, 0), M_STB | M_ALU | (z ? M_PS : 18'h0), rb());
        default: ;
      endcase
    end
  endtask
  task automatic play(input string tag);
    foreach (q[i]) begin
      mem_ready = q[i].r;
      @(negedge clk);
      check($sformatf("%s.c%0d", tag, i), 32'(obs & q[i].m), 32'(q[i].v & q[i].m));
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int nf, nm, s;
    mem_ready = 1'b1;
    funct = 6'b100001;
    #12;
    check("rst_strobes", 32'(obs & 18'h1E000), 0);
    check("rst_flags", {illegal, timeout}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    build(6'b000000, 6'b100001, 0, 0, 0); play("addu");
    build(6'b000100, 6'b000000, 1, 0, 0); play("beq_z1");
    build(6'b000100, 6'b000000, 0, 0, 0); play("beq_z0");
    build(6'b100011, 6'b000000, 0, 0, 3); play("lw_stall");
    for (int k = 0; k < 80; k++) begin
      s = $urandom_range(0, 11);
      nf = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      nm = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      build(ops[s], (s < 5) ? fns[s] : 6'($urandom), rb(), nf, nm);
      play($sformatf("rnd%0d", k));
    end
    check("flags_clean", {illegal, timeout}, 0);
    build(6'b000010, 6'b000000, 0, TO - 1, 0); play("fetch_last");
    check("no_timeout", timeout, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_wait", mem_req, 1);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_err_stb", 32'(obs & M_STB), 0);
      check("to_flag", timeout, 1);
      check("to_alu", alu_op, ADD);
      @(posedge clk);
      #1;
    end
    do_reset();
    check("to_cleared", {illegal, timeout}, 0);
    for (int c = 0; c < 2; c++) begin
      do_reset();
      opcode = c ? 6'b000000 : 6'b111111;
      funct = c ? 6'b100000 : 6'b000000;
      q.delete();
      fetch(0);
      push(pk(0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0), M_STB | M_ALU, 1'b1);
      play("ill_pre");
      for (int i = 0; i < 20; i++) begin
        mem_ready = rb();
        @(negedge clk);
        check("ill_stb", 32'(obs & M_STB), 0);
        check("ill_flags", {illegal, timeout}, 2'b10);
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      #1 check("ill_rst", illegal, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
    opcode = SW_OP;
    q.delete();
    fetch(0);
    push(pk(0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0), M_STB | M_ALU, 1'b1);
    push(pk(0, 0, 0, 0, 0, 0, ADD, 1, 2, 0, 0), M_STB | M_ALU, 1'b1);
    play("sw_pre");
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_mem", {mem_req, mem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("sw_rst", {mem_req, mem_we}, 0);
    check("sw_rst_flags", {illegal, timeout}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {mem_req, mem_we, ir_write}, 3'b100);
    @(posedge clk);
    #1;
    build(6'b000000, 6'b100110, 0, 0, 0); play("post_xor");
    check("end_flags", {illegal, timeout}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
